// File: rtl/des_round_ctrl.sv
// Round sequencer for an iterative DES datapath: load, ROUNDS round strobes, final permutation, result handshake.
// Optional decrypt mode (right-rotate key schedule, key_dir output) is enabled by defining DES_DECRYPT_EN.
module des_round_ctrl #(
  parameter int ROUNDS = 16,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ld_en,
  output logic             round_en,
  output logic [1:0]       key_shift,
  output logic [CNT_W-1:0] round_idx,
  output logic             last_round,
  output logic             fp_en,
`ifdef DES_DECRYPT_EN
  input  logic             decrypt,
  output logic             key_dir,
`endif
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROUNDS - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] w_idx_next;
  logic             w_dec;

  // Rotation amount per round; decrypt skips the rotation before round 0 and rotates right afterwards.
  function automatic logic [1:0] sched(input logic [CNT_W-1:0] idx, input logic dec);
    int unsigned i;
    i = 32'(idx);
    if (dec && (i == 0)) begin
      sched = 2'd0;
    end else begin
      case (i)
        0, 1, 8, 15: sched = 2'd1;
        default:     sched = 2'd2;
      endcase
    end
  endfunction

`ifdef DES_DECRYPT_EN
  logic r_dec;
  logic w_accept;

  assign w_accept = (r_state == S_IDLE) && in_valid && !flush;
  assign w_dec    = r_dec;

  // Mode is captured only on the accept edge so mid-pass changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec <= 1'b0;
    end else if (w_accept) begin
      r_dec <= decrypt;
    end
  end
`else
  assign w_dec = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = '0;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_next = S_LOAD;
      S_LOAD:  w_state_next = S_ROUND;
      S_ROUND: begin
        if (r_idx == LAST_IDX) begin
          w_state_next = S_FINAL;
        end else begin
          w_idx_next = r_idx + CNT_W'(1);
        end
      end
      S_FINAL: w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    // Flush overrides every transition, including an accept in IDLE.
    if (flush) begin
      w_state_next = S_IDLE;
      w_idx_next   = '0;
    end
  end

  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    ld_en      = 1'b0;
    round_en   = 1'b0;
    key_shift  = 2'd0;
    round_idx  = r_idx;
    last_round = 1'b0;
    fp_en      = 1'b0;
    busy       = (r_state != S_IDLE);
`ifdef DES_DECRYPT_EN
    key_dir    = (r_state != S_IDLE) && r_dec;
`endif
    case (r_state)
      S_IDLE:  in_ready = 1'b1;
      S_LOAD:  ld_en = 1'b1;
      S_ROUND: begin
        round_en   = 1'b1;
        key_shift  = sched(r_idx, w_dec);
        last_round = (r_idx == LAST_IDX);
      end
      S_FINAL: fp_en = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_des_round_ctrl.sv
// Bench for des_round_ctrl: directed latency/hold/flush phase, then random traffic with resets and flushes.
module tb_des_round_ctrl;
  localparam int ROUNDS = 16;
  localparam int CNT_W  = 4;
  localparam int NCYC   = 4000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             ld_en;
  logic             round_en;
  logic [1:0]       key_shift;
  logic [CNT_W-1:0] round_idx;
  logic             last_round;
  logic             fp_en;
  logic             busy;
  logic             decrypt;
`ifdef DES_DECRYPT_EN
  logic             key_dir;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  int enc_sched [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  int dec_sched [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Reference: a pass is described by the number of cycles since its accept edge.
  bit m_act;
  int m_k;
  bit m_dec;

  des_round_ctrl #(.ROUNDS(ROUNDS), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ld_en      (ld_en),
    .round_en   (round_en),
    .key_shift  (key_shift),
    .round_idx  (round_idx),
    .last_round (last_round),
    .fp_en      (fp_en),
`ifdef DES_DECRYPT_EN
    .decrypt    (decrypt),
    .key_dir    (key_dir),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int e_ld, e_rnd, e_ks, e_idx, e_last, e_fp, e_ov, e_rdy, e_busy, r;
    e_ld = 0; e_rnd = 0; e_ks = 0; e_idx = 0; e_last = 0; e_fp = 0; e_ov = 0;
    e_rdy  = m_act ? 0 : 1;
    e_busy = m_act ? 1 : 0;
    if (m_act) begin
      if (m_k == 1) e_ld = 1;
      else if (m_k >= 2 && m_k <= ROUNDS + 1) begin
        r      = m_k - 2;
        e_rnd  = 1;
        e_idx  = r;
        e_ks   = m_dec ? dec_sched[r] : enc_sched[r];
        e_last = (r == ROUNDS - 1) ? 1 : 0;
      end
      else if (m_k == ROUNDS + 2) e_fp = 1;
      else e_ov = 1;
    end
    check_eq("in_ready",   32'(in_ready),   32'(e_rdy));
    check_eq("busy",       32'(busy),       32'(e_busy));
    check_eq("ld_en",      32'(ld_en),      32'(e_ld));
    check_eq("round_en",   32'(round_en),   32'(e_rnd));
    check_eq("round_idx",  32'(round_idx),  32'(e_idx));
    check_eq("key_shift",  32'(key_shift),  32'(e_ks));
    check_eq("last_round", 32'(last_round), 32'(e_last));
    check_eq("fp_en",      32'(fp_en),      32'(e_fp));
    check_eq("out_valid",  32'(out_valid),  32'(e_ov));
`ifdef DES_DECRYPT_EN
    check_eq("key_dir",    32'(key_dir),    32'(m_act && m_dec));
`endif
  endtask

  task automatic model_step();
    if (!rst_n || flush) begin
      m_act = 1'b0;
    end else if (!m_act) begin
      if (in_valid) begin
        m_act = 1'b1;
        m_k   = 1;
`ifdef DES_DECRYPT_EN
        m_dec = decrypt;
`else
        m_dec = 1'b0;
`endif
      end
    end else if (m_k >= ROUNDS + 3) begin
      if (out_ready) m_act = 1'b0;
    end else begin
      m_k++;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    decrypt   = 1'b0;
    m_act     = 1'b0;
    m_k       = 0;
    m_dec     = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (cyc > 0) @(negedge clk);
      check_outputs();
      if (cyc < 30) begin
        // First pass straight out of reset; result held for several cycles before being taken.
        in_valid  = 1'b1;
        out_ready = (cyc >= 25);
        flush     = 1'b0;
        decrypt   = 1'b0;
      end else if (cyc < 80) begin
        // Repeated aborts at round index 7, each followed by a fresh accept.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        flush     = m_act && (m_k == 9);
        decrypt   = (cyc >= 55);
      end else begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        flush     = ($urandom_range(0, 59) == 0);
        decrypt   = $urandom_range(0, 1) == 1;
        if (!rst_n) rst_n = 1'b1;
        else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
      end
      model_step();
    end
    @(negedge clk);
    check_outputs();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
